// File: rtl/hpu_axil_pkg.sv
// Shared definitions for the HPU AXI4-Lite control-plane register file:
// bus widths, AXI response codes, slave FSM state encoding and the
// byte-strobe merge helper used by every control register.
package hpu_axil_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  // StAw: address held, waiting for data. StW: data held, waiting for address.
  // StWc: write commit. StRd: read fetch. StR: read data presented.
  typedef enum logic [2:0] {
    StIdle,
    StAw,
    StW,
    StWc,
    StB,
    StRd,
    StR
  } state_e;

  // Replace the bytes of old_val whose strobe bit is set with those of new_val.
  function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old_val,
                                                   input logic [DATA_W-1:0] new_val,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_regfile_if.sv
// AXI4-Lite bus bundle (32-bit data, 4-bit strobe) for the register file.
//   master modport: drives addresses, write data, strobes, valids and
//                   response readies.
//   slave modport:  drives address/data readies, BRESP/BVALID and
//                   RDATA/RRESP/RVALID.
interface axil_regfile_if #(
  parameter int unsigned ADDR_W = 12
);
  import hpu_axil_pkg::*;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  resp_t             bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  resp_t             rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/hpu_ctrl_reg.sv
// One 32-bit control register with byte-strobe merge, self-clearing pulse
// bits and a one-cycle write strobe.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   wr_en_i       : commit wdata_i under wstrb_i this cycle
//   wdata_i       : write data
//   wstrb_i       : byte strobes
//   q_o           : register contents
//   we_o          : high for the cycle after a commit
module hpu_ctrl_reg
  import hpu_axil_pkg::*;
#(
  parameter logic [DATA_W-1:0] PULSE_MASK = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  output logic [DATA_W-1:0] q_o,
  output logic              we_o
);

  logic [DATA_W-1:0] q_d, q_q;
  logic              we_d, we_q;

  always_comb begin
    // Pulse bits live for exactly one cycle, then drop unless rewritten.
    q_d = q_q & ~PULSE_MASK;
    if (wr_en_i) begin
      q_d = strb_merge(q_d, wdata_i, wstrb_i);
    end
    // Strobe fires even when no byte lane is enabled.
    we_d = wr_en_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q  <= '0;
      we_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      we_q <= we_d;
    end
  end

  assign q_o  = q_q;
  assign we_o = we_q;

endmodule

// File: rtl/axil_regfile.sv
// AXI4-Lite slave register file for the HPU control plane.
//   S_AXI_ACLK    : sole clock
//   S_AXI_ARESETN : asynchronous active-low reset
//   s_axi         : AXI4-Lite slave bus
//   ctrl_o        : NUM_CTRL control words, register k at [32k+31:32k]
//   ctrl_we_o     : bit k high for one cycle after register k is written
//   stat_i        : NUM_STAT status words, sampled in the read fetch cycle
// Word index = address[ADDR_W-1:2]. Indices below NUM_CTRL are read/write,
// the next NUM_STAT are read-only (writes get SLVERR), anything else DECERR.
module axil_regfile
  import hpu_axil_pkg::*;
#(
  parameter int unsigned       NUM_CTRL   = 4,
  parameter int unsigned       NUM_STAT   = 4,
  parameter int unsigned       ADDR_W     = 12,
  parameter logic [DATA_W-1:0] PULSE_MASK = '0
) (
  input  logic                                               S_AXI_ACLK,
  input  logic                                               S_AXI_ARESETN,
  axil_regfile_if.slave                                      s_axi,
  output logic [DATA_W*NUM_CTRL-1:0]                         ctrl_o,
  output logic [NUM_CTRL-1:0]                                ctrl_we_o,
  input  logic [DATA_W*((NUM_STAT > 0) ? NUM_STAT : 1)-1:0]  stat_i
);

  localparam int unsigned            IDX_W     = ADDR_W - 2;
  localparam logic [IDX_W-1:0]       CTRL_LIM  = IDX_W'(NUM_CTRL);
  localparam logic [IDX_W-1:0]       TOTAL_LIM = IDX_W'(NUM_CTRL + NUM_STAT);

  state_e            state_d, state_q;
  logic [IDX_W-1:0]  addr_d, addr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic [STRB_W-1:0] wstrb_d, wstrb_q;
  resp_t             bresp_d, bresp_q;
  logic              bvalid_d, bvalid_q;
  logic [DATA_W-1:0] rdata_d, rdata_q;
  resp_t             rresp_d, rresp_q;
  logic              rvalid_d, rvalid_q;

  logic              ctrl_hit, stat_hit;
  logic [DATA_W-1:0] rd_val;
  logic [NUM_CTRL-1:0] wr_en;

  // Byte-offset bits carry no information on a word-only bus.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  assign ctrl_hit = (addr_q < CTRL_LIM);
  assign stat_hit = !ctrl_hit && (addr_q < TOTAL_LIM);

  // Ready rules: a pending write request in IDLE blocks the read address.
  assign s_axi.awready = (state_q == StIdle) || (state_q == StW);
  assign s_axi.wready  = (state_q == StIdle) || (state_q == StAw);
  assign s_axi.arready = (state_q == StIdle) && !s_axi.awvalid && !s_axi.wvalid;

  assign s_axi.bresp  = bresp_q;
  assign s_axi.bvalid = bvalid_q;
  assign s_axi.rdata  = rdata_q;
  assign s_axi.rresp  = rresp_q;
  assign s_axi.rvalid = rvalid_q;

  always_comb begin
    for (int k = 0; k < int'(NUM_CTRL); k++) begin
      wr_en[k] = (state_q == StWc) && (addr_q == IDX_W'(k));
    end
  end

  always_comb begin
    rd_val = '0;
    for (int k = 0; k < int'(NUM_CTRL); k++) begin
      if (addr_q == IDX_W'(k)) begin
        rd_val = ctrl_o[DATA_W*k +: DATA_W];
      end
    end
    for (int k = 0; k < int'(NUM_STAT); k++) begin
      if (addr_q == IDX_W'(int'(NUM_CTRL) + k)) begin
        rd_val = stat_i[DATA_W*k +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bresp_d  = bresp_q;
    bvalid_d = bvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rvalid_d = rvalid_q;

    unique case (state_q)
      StIdle: begin
        if (s_axi.awvalid && s_axi.wvalid) begin
          addr_d  = s_axi.awaddr[ADDR_W-1:2];
          wdata_d = s_axi.wdata;
          wstrb_d = s_axi.wstrb;
          state_d = StWc;
        end else if (s_axi.awvalid) begin
          addr_d  = s_axi.awaddr[ADDR_W-1:2];
          state_d = StAw;
        end else if (s_axi.wvalid) begin
          wdata_d = s_axi.wdata;
          wstrb_d = s_axi.wstrb;
          state_d = StW;
        end else if (s_axi.arvalid) begin
          addr_d  = s_axi.araddr[ADDR_W-1:2];
          state_d = StRd;
        end
      end
      StAw: begin
        if (s_axi.wvalid) begin
          wdata_d = s_axi.wdata;
          wstrb_d = s_axi.wstrb;
          state_d = StWc;
        end
      end
      StW: begin
        if (s_axi.awvalid) begin
          addr_d  = s_axi.awaddr[ADDR_W-1:2];
          state_d = StWc;
        end
      end
      StWc: begin
        // The register update itself happens in hpu_ctrl_reg via wr_en.
        bvalid_d = 1'b1;
        bresp_d  = ctrl_hit ? RESP_OKAY : (stat_hit ? RESP_SLVERR : RESP_DECERR);
        state_d  = StB;
      end
      StB: begin
        if (s_axi.bready) begin
          bvalid_d = 1'b0;
          state_d  = StIdle;
        end
      end
      StRd: begin
        rvalid_d = 1'b1;
        rdata_d  = rd_val;
        rresp_d  = (ctrl_hit || stat_hit) ? RESP_OKAY : RESP_DECERR;
        state_d  = StR;
      end
      StR: begin
        if (s_axi.rready) begin
          rvalid_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
      bvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
      bvalid_q <= bvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rvalid_q <= rvalid_d;
    end
  end

  for (genvar k = 0; k < int'(NUM_CTRL); k++) begin : g_ctrl
    hpu_ctrl_reg #(
      .PULSE_MASK((k == 0) ? PULSE_MASK : '0)
    ) u_ctrl_reg (
      .clk_i   (S_AXI_ACLK),
      .rst_ni  (S_AXI_ARESETN),
      .wr_en_i (wr_en[k]),
      .wdata_i (wdata_q),
      .wstrb_i (wstrb_q),
      .q_o     (ctrl_o[DATA_W*k +: DATA_W]),
      .we_o    (ctrl_we_o[k])
    );
  end

endmodule

// File: tb/tb_axil_regfile.sv
module tb_axil_regfile;

  localparam int unsigned NC = 4;
  localparam int unsigned NS = 4;
  localparam logic [31:0] PMASK = 32'h4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axil_regfile_if #(.ADDR_W(12)) bus ();

  logic [32*NC-1:0] ctrl;
  logic [NC-1:0]    ctrl_we;
  logic [32*NS-1:0] stat;

  axil_regfile #(
    .NUM_CTRL   (NC),
    .NUM_STAT   (NS),
    .ADDR_W     (12),
    .PULSE_MASK (PMASK)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (bus),
    .ctrl_o        (ctrl),
    .ctrl_we_o     (ctrl_we),
    .stat_i        (stat)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: what software should see in each register.
  logic [31:0] m_ctrl [NC];
  logic [31:0] m_stat [NS];

  always_comb begin
    for (int k = 0; k < int'(NS); k++) stat[32*k +: 32] = m_stat[k];
  end

  function automatic logic [31:0] model_merge(input logic [31:0] old_v, input logic [31:0] d,
                                              input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_v & ~m) | (d & m);
  endfunction

  function automatic logic [32*NC-1:0] model_vec();
    logic [32*NC-1:0] v;
    for (int k = 0; k < int'(NC); k++) v[32*k +: 32] = m_ctrl[k];
    return v;
  endfunction

  function automatic logic [1:0] model_wresp(input int idx);
    if (idx < int'(NC)) return 2'b00;
    if (idx < int'(NC + NS)) return 2'b10;
    return 2'b11;
  endfunction

  // Issues AW and W together; returns at the negedge where BVALID is first seen
  // (lat = negedges waited after the address/data handshake).
  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          input bit brdy, output logic [1:0] resp, output int lat);
    bit awp, wp, awh, wh;
    int n;
    @(negedge clk);
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    bus.bready = brdy;
    awp = 1'b1; wp = 1'b1; n = 0;
    while ((awp || wp) && n < 20) begin
      #1;
      awh = bus.awvalid && bus.awready;
      wh  = bus.wvalid && bus.wready;
      @(negedge clk);
      n++;
      if (awh) begin bus.awvalid = 1'b0; awp = 1'b0; end
      if (wh) begin bus.wvalid = 1'b0; wp = 1'b0; end
    end
    lat = 0;
    while (!bus.bvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    resp = bus.bresp;
    if (!bus.bvalid) begin
      checks++; errors++;
      $display("FAIL write_timeout addr=%h bvalid=%b required 1", a, bus.bvalid);
    end
  endtask

  // Returns at the negedge where RVALID is first seen.
  task automatic do_read(input logic [11:0] a, input bit rrdy, output logic [31:0] d,
                         output logic [1:0] resp, output int lat);
    bit arh;
    int n;
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = rrdy;
    n = 0;
    while (bus.arvalid && n < 20) begin
      #1;
      arh = bus.arready;
      @(negedge clk);
      n++;
      if (arh) bus.arvalid = 1'b0;
    end
    lat = 0;
    while (!bus.rvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = bus.rdata;
    resp = bus.rresp;
    if (!bus.rvalid) begin
      checks++; errors++;
      $display("FAIL read_timeout addr=%h rvalid=%b required 1", a, bus.rvalid);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.bvalid, bus.rvalid, bus.bresp, bus.rresp} !== 6'b0) begin
      errors++;
      $display("FAIL reset_resp got %b required 000000",
               {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp});
    end
    checks++;
    if (ctrl !== '0 || ctrl_we !== '0 || bus.rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs ctrl=%h we=%b rdata=%h required 0", ctrl, ctrl_we, bus.rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_ready got %b required 111", {bus.awready, bus.wready, bus.arready});
    end
  endtask

  task automatic test_basic_write();
    logic [1:0] resp;
    int lat;
    do_write(12'h000, 32'h7, 4'hF, 1'b1, resp, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL wr_latency got %0d required 1", lat); end
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL wr_okay got %b required 00", resp); end
    checks++;
    if (ctrl[31:0] !== 32'h7) begin
      errors++; $display("FAIL wr_value got %h required 00000007", ctrl[31:0]);
    end
    checks++;
    if (ctrl_we !== 4'b0001) begin errors++; $display("FAIL wr_we got %b required 0001", ctrl_we); end
    m_ctrl[0] = 32'h7 & ~PMASK;
    @(negedge clk);
    checks++;
    if (ctrl_we !== 4'b0000) begin
      errors++; $display("FAIL wr_we_clear got %b required 0000", ctrl_we);
    end
    checks++;
    if (ctrl[31:0] !== 32'h3) begin
      errors++; $display("FAIL pulse_clear got %h required 00000003", ctrl[31:0]);
    end
    checks++;
    if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL b_done got %b required 0", bus.bvalid); end
  endtask

  task automatic test_strobe();
    logic [1:0] resp;
    logic [31:0] d;
    int lat;
    do_write(12'h004, 32'h11223344, 4'hF, 1'b1, resp, lat);
    do_write(12'h004, 32'hAABBCCDD, 4'b0101, 1'b1, resp, lat);
    m_ctrl[1] = 32'h11BB33DD;
    do_read(12'h004, 1'b1, d, resp, lat);
    checks++;
    if (d !== 32'h11BB33DD) begin errors++; $display("FAIL strb_merge got %h required 11BB33DD", d); end
    checks++;
    if (resp !== 2'b00 || lat !== 1) begin
      errors++; $display("FAIL strb_rd resp=%b lat=%0d required 00/1", resp, lat);
    end
    do_write(12'h004, 32'hFFFFFFFF, 4'b0000, 1'b1, resp, lat);
    checks++;
    if (resp !== 2'b00 || ctrl_we !== 4'b0010 || ctrl[63:32] !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL strb_zero resp=%b we=%b val=%h required 00/0010/11BB33DD",
               resp, ctrl_we, ctrl[63:32]);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp;
    logic [31:0] d;
    int lat;
    @(negedge clk);
    bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b1;
    #1;
    checks++;
    if (bus.wready !== 1'b1) begin errors++; $display("FAIL w_first_ready got %b required 1", bus.wready); end
    @(negedge clk);
    bus.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({bus.awready, bus.wready} !== 2'b10) begin
        errors++;
        $display("FAIL w_hold_ready got %b required 10", {bus.awready, bus.wready});
      end
      @(negedge clk);
    end
    bus.awaddr = 12'h008; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    lat = 0;
    while (!bus.bvalid && lat < 20) begin @(negedge clk); lat++; end
    checks++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || lat !== 1) begin
      errors++;
      $display("FAIL w_then_aw bvalid=%b bresp=%b lat=%0d required 1/00/1",
               bus.bvalid, bus.bresp, lat);
    end
    m_ctrl[2] = 32'hDEADBEEF;
    do_read(12'h008, 1'b1, d, resp, lat);
    checks++;
    if (d !== m_ctrl[2]) begin errors++; $display("FAIL w_then_aw_rd got %h required %h", d, m_ctrl[2]); end
  endtask

  task automatic test_collision();
    bit arh;
    int n;
    logic [31:0] wd;
    wd = $urandom;
    @(negedge clk);
    bus.awaddr = 12'h00C; bus.awvalid = 1'b1;
    bus.wdata = wd; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = 12'h00C; bus.arvalid = 1'b1;
    bus.bready = 1'b1; bus.rready = 1'b1;
    #1;
    checks++;
    if (bus.arready !== 1'b0) begin errors++; $display("FAIL col_arready got %b required 0", bus.arready); end
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    m_ctrl[3] = wd;
    n = 0;
    while (!bus.bvalid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || bus.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL col_write bvalid=%b bresp=%b rvalid=%b required 1/00/0",
               bus.bvalid, bus.bresp, bus.rvalid);
    end
    n = 0;
    while (!bus.rvalid && n < 20) begin
      #1;
      arh = bus.arvalid && bus.arready;
      @(negedge clk);
      n++;
      if (arh) bus.arvalid = 1'b0;
    end
    checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== m_ctrl[3] || bus.rresp !== 2'b00) begin
      errors++;
      $display("FAIL col_read rvalid=%b rdata=%h rresp=%b required 1/%h/00",
               bus.rvalid, bus.rdata, bus.rresp, m_ctrl[3]);
    end
    bus.arvalid = 1'b0;
  endtask

  task automatic test_decode();
    logic [1:0] resp;
    logic [31:0] d, held;
    int lat;
    do_write(12'h010, 32'h12345678, 4'hF, 1'b1, resp, lat);
    checks++;
    if (resp !== 2'b10 || ctrl_we !== 4'b0000) begin
      errors++; $display("FAIL stat_write resp=%b we=%b required 10/0000", resp, ctrl_we);
    end
    do_write(12'h040, 32'h12345678, 4'hF, 1'b1, resp, lat);
    checks++;
    if (resp !== 2'b11 || ctrl_we !== 4'b0000) begin
      errors++; $display("FAIL dec_write resp=%b we=%b required 11/0000", resp, ctrl_we);
    end
    @(negedge clk);
    checks++;
    if (ctrl !== model_vec()) begin
      errors++; $display("FAIL err_no_update got %h required %h", ctrl, model_vec());
    end
    do_read(12'h020, 1'b1, d, resp, lat);
    checks++;
    if (d !== 32'h0 || resp !== 2'b11) begin
      errors++; $display("FAIL dec_read data=%h resp=%b required 00000000/11", d, resp);
    end
    m_stat[0] = 32'hCAFEF00D;
    do_read(12'h010, 1'b1, d, resp, lat);
    checks++;
    if (d !== 32'hCAFEF00D || resp !== 2'b00) begin
      errors++; $display("FAIL stat_read data=%h resp=%b required CAFEF00D/00", d, resp);
    end
    // RDATA must hold while RREADY is low even as the status word moves.
    m_stat[1] = $urandom;
    held = m_stat[1];
    do_read(12'h014, 1'b0, d, resp, lat);
    for (int i = 0; i < 3; i++) begin
      m_stat[1] = $urandom;
      @(negedge clk);
      checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== held) begin
        errors++;
        $display("FAIL r_hold rvalid=%b rdata=%h required 1/%h", bus.rvalid, bus.rdata, held);
      end
    end
    bus.rready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL r_release got %b required 0", bus.rvalid); end
  endtask

  task automatic test_random();
    logic [1:0] resp, eresp;
    logic [31:0] d, edata, vis;
    logic [3:0] s, ewe;
    logic [11:0] a;
    int idx, lat;
    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(0, 9);
      a = 12'(idx * 4);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom);
        eresp = model_wresp(idx);
        ewe = '0;
        vis = '0;
        if (idx < int'(NC)) begin
          ewe[idx] = 1'b1;
          vis = model_merge(m_ctrl[idx], d, s);
          m_ctrl[idx] = vis;
        end
        do_write(a, d, s, 1'b1, resp, lat);
        checks++;
        if (resp !== eresp || ctrl_we !== ewe) begin
          errors++;
          $display("FAIL rnd_write idx=%0d resp=%b we=%b required %b/%b", idx, resp, ctrl_we,
                   eresp, ewe);
        end
        if (idx < int'(NC)) begin
          checks++;
          if (ctrl[32*idx +: 32] !== vis) begin
            errors++;
            $display("FAIL rnd_visible idx=%0d got %h required %h", idx, ctrl[32*idx +: 32], vis);
          end
        end
        if (idx == 0) m_ctrl[0] = m_ctrl[0] & ~PMASK;
        @(negedge clk);
        checks++;
        if (ctrl !== model_vec()) begin
          errors++; $display("FAIL rnd_ctrl got %h required %h", ctrl, model_vec());
        end
      end else begin
        for (int k = 0; k < int'(NS); k++) m_stat[k] = $urandom;
        if (idx < int'(NC)) begin
          edata = m_ctrl[idx]; eresp = 2'b00;
        end else if (idx < int'(NC + NS)) begin
          edata = m_stat[idx - int'(NC)]; eresp = 2'b00;
        end else begin
          edata = 32'h0; eresp = 2'b11;
        end
        do_read(a, 1'b1, d, resp, lat);
        checks++;
        if (d !== edata || resp !== eresp || lat !== 1) begin
          errors++;
          $display("FAIL rnd_read idx=%0d data=%h resp=%b lat=%0d required %h/%b/1", idx, d,
                   resp, lat, edata, eresp);
        end
      end
    end
  endtask

  task automatic test_reset_mid_b();
    logic [1:0] resp;
    int lat;
    do_write(12'h00C, 32'h0BADF00D, 4'hF, 1'b0, resp, lat);
    m_ctrl[3] = 32'h0BADF00D;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.bvalid !== 1'b1) begin errors++; $display("FAIL b_wait got %b required 1", bus.bvalid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.bvalid !== 1'b0 || ctrl !== '0) begin
      errors++; $display("FAIL mid_reset bvalid=%b ctrl=%h required 0/0", bus.bvalid, ctrl);
    end
    for (int k = 0; k < int'(NC); k++) m_ctrl[k] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_write(12'h008, 32'h5A5A1234, 4'hF, 1'b1, resp, lat);
    m_ctrl[2] = 32'h5A5A1234;
    checks++;
    if (resp !== 2'b00 || lat !== 1 || ctrl !== model_vec()) begin
      errors++;
      $display("FAIL post_reset_write resp=%b lat=%0d ctrl=%h required 00/1/%h", resp, lat,
               ctrl, model_vec());
    end
    @(negedge clk);
  endtask

  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    for (int k = 0; k < int'(NC); k++) m_ctrl[k] = '0;
    for (int k = 0; k < int'(NS); k++) m_stat[k] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic_write();
    test_strobe();
    test_w_before_aw();
    test_collision();
    test_decode();
    test_random();
    test_reset_mid_b();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_regfile.md
# axil_regfile

Parametrised AXI4-Lite slave register file for the HPU control plane, sitting between the PS AXI-Lite port and the stream/compute datapath. It provides NUM_CTRL read/write control registers with byte strobes and self-clearing pulse bits, plus NUM_STAT read-only status registers sampled from the datapath. It returns OKAY, SLVERR or DECERR responses and drives a one-cycle write-strobe per control register.

## Interface
- NUM_CTRL, 4: read/write control registers at word indices 0..NUM_CTRL-1 (1..64)
- NUM_STAT, 4: read-only status registers at indices NUM_CTRL..NUM_CTRL+NUM_STAT-1 (0..64)
- ADDR_W, 12: significant AXI address bits; word index = ADDR[ADDR_W-1:2]
- PULSE_MASK, 32'h0: bits of control register 0 that self-clear
- S_AXI_ACLK  in  1  sole clock
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low
- S_AXI_AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY: AXI4-Lite write channels (32-bit data, 4-bit strobe)
- S_AXI_ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: AXI4-Lite read channels
- ctrl_o  out  32*NUM_CTRL  control register contents, register k at [32k+31:32k]
- ctrl_we_o  out  NUM_CTRL  bit k high for one cycle after register k is written
- stat_i  in  32*NUM_STAT  status words, sampled at read time

## Operation
- States: IDLE, AW (address held, waiting data), W (data held, waiting address), WC (write commit), B (response), RD (read fetch), R (read data).
- AWREADY = IDLE|W; WREADY = IDLE|AW; ARREADY = IDLE and no AWVALID/WVALID.
- IDLE: AWVALID&WVALID -> WC; AWVALID only -> AW; WVALID only -> W; else ARVALID -> RD. Write always wins over read in the same cycle.
- AW + WVALID -> WC; W + AWVALID -> WC. Address/data/strobe latched at handshake.
- WC (one cycle): index < NUM_CTRL -> bytes with WSTRB=1 merged into register; ctrl_we_o[index] set; BRESP=OKAY. Index in status range -> no update, SLVERR (2'b10). Index beyond both -> no update, DECERR (2'b11). WC -> B.
- B: BVALID=1, BRESP held; BREADY -> IDLE.
- RD (one cycle): RDATA <= control reg, stat_i word, or 0; RRESP = OKAY for both in-range classes, DECERR out of range. RD -> R.
- R: RVALID=1; RDATA/RRESP held stable until RREADY -> IDLE.
- Pulse bits: a PULSE_MASK bit of register 0 written to 1 reads 1 on ctrl_o for exactly one cycle, then clears; a read in that cycle returns 1.
- WSTRB=4'b0000 to a control register: no data change, ctrl_we_o still pulses, OKAY.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, all ctrl_o=0, ctrl_we_o=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0. Mid-transaction reset aborts the transaction with no response.
- Write latency: AW&W in same IDLE cycle (edge 0) -> WC cycle 1 -> ctrl_o/ctrl_we_o updated and BVALID high from cycle 2.
- Read latency: AR at edge 0 -> RD cycle 1 (stat_i sampled) -> RVALID from cycle 2.
- Minimum back-to-back: 3 cycles per transaction with BREADY/RREADY held high.
- All outputs registered; no combinational path from any input to any output other than the READY rules above.

## Structure
- Package hpu_axil_pkg: state encoding, AXI response localparams (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11), DATA_W=32.
- Sub-module hpu_ctrl_reg: one 32-bit register with strobe merge, pulse mask and we strobe; instantiated NUM_CTRL times via generate (PULSE_MASK only on instance 0, 0 elsewhere).
- FSM, address decode and read mux stay in axil_regfile.

## Test plan
- Write 0x00000007 to 0x000, WSTRB=4'hF, AW/W together -> BVALID cycle 2, BRESP=00, ctrl_o[31:0]=7, ctrl_we_o[0] one cycle.
- PULSE_MASK=32'h4, write 0x7 to 0x000 -> ctrl_o bit2 high one cycle then 0; bits 1:0 stay 1.
- Write 0xAABBCCDD with WSTRB=4'b0101 over 0x11223344 at 0x004 -> readback 0x11BB33DD, RRESP=00.
- W before AW by 3 cycles, then AW; simultaneous AR and AW in IDLE -> write completes first, read follows, both responses correct.
- Write to status index (0x010 with NUM_CTRL=4) -> SLVERR, no ctrl_we_o; read at index 8 -> RDATA=0, DECERR; read 0x010 with stat_i[31:0]=0xCAFEF00D -> 0xCAFEF00D, OKAY.
- Assert reset during B with BREADY low -> BVALID=0 immediately, ctrl_o=0, next write accepted normally.
